// File: rtl/dmem_access_ctrl.sv
// Memory-stage load/store sequencer: drives a word-wide req/gnt/rvalid data port,
// splits accesses that straddle a word into two beats and extends load data.
module dmem_access_ctrl #(
    parameter int ADDR_W         = 32,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [1:0]        mem_size,
    input  logic              sz_ex,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [31:0]       m_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        DONE,
        ERR
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              sz_ex_q;
    logic              we_q;
    logic [31:0]       beat0_q;
    logic [31:0]       beat1_q;

    logic              active;
    logic              size_bad;
    logic              misaligned;
    logic              start;
    logic              reject;

    logic [3:0]        lane_mask;
    logic [7:0]        be_span;
    logic [63:0]       wd_span;
    logic              split;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       merged;
    logic [31:0]       load_ext;

    assign active     = req_valid & (wr_en | rd_en);
    assign size_bad   = (mem_size == 2'b11);
    assign misaligned = ((mem_size == 2'b01) & addr[0]) |
                        ((mem_size == 2'b10) & (addr[1:0] != 2'b00));
    assign start      = active & ~size_bad & ((ALLOW_MISALIGN != 1'b0) | ~misaligned);
    assign reject     = active & (size_bad | ((ALLOW_MISALIGN == 1'b0) & misaligned));

    always_comb begin
        lane_mask = 4'b1111;
        case (size_q)
            2'b00:   lane_mask = 4'b0001;
            2'b01:   lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    // Lanes/data spanning two words: low half is beat0, high half is beat1.
    assign be_span   = {4'b0000, lane_mask} << addr_q[1:0];
    assign wd_span   = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
    assign split     = |be_span[7:4];
    assign base_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign next_addr = base_addr + ADDR_W'(4);

    assign merged = 32'({beat1_q, beat0_q} >> {addr_q[1:0], 3'b000});

    always_comb begin
        load_ext = merged;
        case (size_q)
            2'b00:   load_ext = {{24{sz_ex_q & merged[7]}}, merged[7:0]};
            2'b01:   load_ext = {{16{sz_ex_q & merged[15]}}, merged[15:0]};
            default: load_ext = merged;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sz_ex_q <= 1'b0;
            we_q    <= 1'b0;
            beat0_q <= '0;
            beat1_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                size_q  <= mem_size;
                sz_ex_q <= sz_ex;
                we_q    <= wr_en;
                beat0_q <= '0;
                beat1_q <= '0;
            end
            if (state == WAIT0 && m_rvalid) begin
                beat0_q <= m_rdata;
            end
            if (state == WAIT1 && m_rvalid) begin
                beat1_q <= m_rdata;
            end
        end
    end

    // Bus fields are driven only while requesting so the port idles at zero.
    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        m_req    = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_be     = '0;
        m_wdata  = '0;
        rdata    = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    stall    = 1'b1;
                    state_nx = REQ0;
                end else if (reject) begin
                    state_nx = ERR;
                end
            end
            REQ0: begin
                stall   = 1'b1;
                m_req   = 1'b1;
                m_we    = we_q;
                m_addr  = base_addr;
                m_be    = be_span[3:0];
                m_wdata = wd_span[31:0];
                if (m_gnt) begin
                    if (!we_q) begin
                        state_nx = WAIT0;
                    end else if (split) begin
                        state_nx = REQ1;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            WAIT0: begin
                stall = 1'b1;
                if (m_rvalid) begin
                    state_nx = split ? REQ1 : DONE;
                end
            end
            REQ1: begin
                stall   = 1'b1;
                m_req   = 1'b1;
                m_we    = we_q;
                m_addr  = next_addr;
                m_be    = be_span[7:4];
                m_wdata = wd_span[63:32];
                if (m_gnt) begin
                    state_nx = we_q ? DONE : WAIT1;
                end
            end
            WAIT1: begin
                stall = 1'b1;
                if (m_rvalid) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                rdata    = we_q ? 32'h0 : load_ext;
                state_nx = IDLE;
            end
            ERR: begin
                err      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-level memory reference model plus a word-wide
// memory responder; directed test-plan cases followed by random accesses.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_valid2;
    logic        wr_en, rd_en, sz_ex;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata;
    logic        m_gnt, m_rvalid;
    logic [31:0] m_rdata;

    logic        stall, done, err, m_req, m_we;
    logic [31:0] rdata, m_addr, m_wdata;
    logic [3:0]  m_be;

    logic        stall_b, done_b, err_b, m_req_b, m_we_b;
    logic [31:0] rdata_b, m_addr_b, m_wdata_b;
    logic [3:0]  m_be_b;

    dmem_access_ctrl #(.ADDR_W(32), .ALLOW_MISALIGN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .wr_en(wr_en), .rd_en(rd_en),
        .mem_size(mem_size), .sz_ex(sz_ex), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata), .err(err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    dmem_access_ctrl #(.ADDR_W(32), .ALLOW_MISALIGN(1'b0)) dut_strict (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .wr_en(wr_en), .rd_en(rd_en),
        .mem_size(mem_size), .sz_ex(sz_ex), .addr(addr), .wdata(wdata),
        .stall(stall_b), .done(done_b), .rdata(rdata_b), .err(err_b),
        .m_req(m_req_b), .m_we(m_we_b), .m_addr(m_addr_b), .m_be(m_be_b), .m_wdata(m_wdata_b),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    int n_compared = 0;
    int n_mismatch = 0;

    logic [31:0] word_mem [logic [31:0]];
    logic [7:0]  ref_mem  [logic [31:0]];

    int          last_cycles;
    int          last_stall_cycles;
    logic [31:0] last_rdata;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatch++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return word_mem.exists(a) ? word_mem[a] : 32'h0;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        word_mem[w] = d;
        for (int i = 0; i < 4; i++) ref_mem[w + i] = d[8*i +: 8];
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete access with a memory responder that grants after gnt_wait
    // request cycles and returns read data rv_wait cycles after the grant.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sx,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input int gnt_wait, input int rv_wait);
        int          n;
        int          b;
        int          beat;
        int          req_cnt;
        int          rv_cnt;
        int          exp_beats;
        bit          fin;
        logic [31:0] ai, wi, w0, rv_data, exp_rd, mask, upd;
        logic [31:0] exp_addr [2];
        logic [3:0]  exp_be   [2];
        logic [31:0] exp_wd   [2];

        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        w0 = {a[31:2], 2'b00};
        exp_beats = 1;
        for (int k = 0; k < 2; k++) begin
            exp_addr[k] = 32'h0; exp_be[k] = 4'h0; exp_wd[k] = 32'h0;
        end
        exp_rd = 32'h0;
        for (int i = 0; i < n; i++) begin
            ai = a + i;
            wi = {ai[31:2], 2'b00};
            b  = (wi == w0) ? 0 : 1;
            if (b == 1) exp_beats = 2;
            exp_addr[b] = wi;
            exp_be[b][ai[1:0]] = 1'b1;
            exp_wd[b][8*ai[1:0] +: 8] = wd[8*i +: 8];
            exp_rd[8*i +: 8] = ref_byte(ai);
        end
        if (sx && n < 4 && exp_rd[8*n-1]) begin
            for (int k = 8*n; k < 32; k++) exp_rd[k] = 1'b1;
        end

        @(negedge clk);
        req_valid = 1'b1; wr_en = we; rd_en = we ? 1'($urandom) : 1'b1;
        mem_size = size; sz_ex = sx; addr = a; wdata = wd;
        m_gnt = 1'b0; m_rvalid = 1'b0;
        #1;
        checkOutput("idle_stall", stall, 1'b1);
        checkOutput("idle_mreq", m_req, 1'b0);

        beat = 0; req_cnt = 0; rv_cnt = -1; rv_data = 32'h0; fin = 0;
        last_cycles = 0; last_stall_cycles = 0;
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            @(negedge clk);
            #1;
            m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = $urandom;
            last_cycles++;
            if (done) begin
                fin = 1;
            end else begin
                if (stall) last_stall_cycles++;
                checkOutput("busy_stall", stall, 1'b1);
                if (m_req) begin
                    b = (beat < 2) ? beat : 1;
                    checkOutput("m_addr", m_addr, exp_addr[b]);
                    checkOutput("m_be", m_be, exp_be[b]);
                    checkOutput("m_we", m_we, we);
                    for (int j = 0; j < 4; j++) mask[8*j +: 8] = {8{exp_be[b][j]}};
                    if (we) checkOutput("m_wdata", m_wdata & mask, exp_wd[b]);
                    if (req_cnt == gnt_wait) begin
                        m_gnt = 1'b1;
                        req_cnt = 0;
                        if (we) begin
                            upd = mem_word(m_addr);
                            for (int j = 0; j < 4; j++)
                                if (m_be[j]) upd[8*j +: 8] = m_wdata[8*j +: 8];
                            word_mem[m_addr] = upd;
                        end else begin
                            rv_cnt  = rv_wait;
                            rv_data = mem_word(m_addr);
                        end
                        beat++;
                    end else begin
                        req_cnt++;
                    end
                end else if (rv_cnt == 0) begin
                    m_rvalid = 1'b1;
                    m_rdata  = rv_data;
                    rv_cnt   = -1;
                end else if (rv_cnt > 0) begin
                    rv_cnt--;
                end
            end
        end

        checkOutput("done", done, 1'b1);
        checkOutput("done_stall", stall, 1'b0);
        checkOutput("done_mreq", m_req, 1'b0);
        checkOutput("beats", beat, exp_beats);
        if (!we) checkOutput("rdata", rdata, exp_rd);
        last_rdata = rdata;
        req_valid = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
        end
        @(negedge clk);
        #1;
        checkOutput("done_pulse", done, 1'b0);
        if (!fin) pulse_reset();
    endtask

    task automatic applyError(input logic [31:0] a);
        @(negedge clk);
        req_valid = 1'b1; wr_en = 1'($urandom); rd_en = 1'b1;
        mem_size = 2'b11; sz_ex = 1'($urandom); addr = a; wdata = $urandom;
        #1;
        checkOutput("err_idle_stall", stall, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("err_pulse", err, 1'b1);
        checkOutput("err_mreq", m_req, 1'b0);
        checkOutput("err_stall", stall, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("err_clear", err, 1'b0);
        checkOutput("err_nomreq", m_req, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rs;

        rst = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        mem_size = 2'b00; sz_ex = 1'b0; addr = 32'h0; wdata = 32'h0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_stall", stall, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_mreq", m_req, 1'b0);
        checkOutput("rst_mbe", m_be, 4'h0);
        checkOutput("rst_rdata", rdata, 32'h0);
        rst = 1'b0;

        $display("[TB] aligned word store");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0);
        checkOutput("store_latency", last_cycles, 2);
        checkOutput("store_stall_cycles", last_stall_cycles, 1);
        checkOutput("store_mem", mem_word(32'h0000_0100), 32'hDEAD_BEEF);

        $display("[TB] byte loads with sign and zero extension");
        preload(32'h0000_0200, 32'h8011_2233);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0, 0, 0);
        checkOutput("tp_byte_sext", last_rdata, 32'hFFFF_FF80);
        checkOutput("load_latency", last_cycles, 3);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0, 1, 2);
        checkOutput("tp_byte_zext", last_rdata, 32'h0000_0080);

        $display("[TB] misaligned word load");
        preload(32'h0000_0104, 32'hAABB_CCDD);
        preload(32'h0000_0108, 32'h1122_3344);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0106, 32'h0, 0, 0);
        checkOutput("tp_split_load", last_rdata, 32'h3344_AABB);

        $display("[TB] misaligned half store across address wrap");
        applyStimulus(1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1, 0);
        checkOutput("wrap_mem_hi", mem_word(32'hFFFF_FFFC) & 32'hFF00_0000, 32'h3400_0000);
        checkOutput("wrap_mem_lo", mem_word(32'h0000_0000) & 32'h0000_00FF, 32'h0000_0012);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0, 0, 1);
        checkOutput("wrap_load", last_rdata, 32'h0000_1234);

        $display("[TB] illegal size");
        applyError(32'h0000_0040);

        $display("[TB] misaligned access with splitting disabled");
        @(negedge clk);
        req_valid2 = 1'b1; wr_en = 1'b0; rd_en = 1'b1; mem_size = 2'b10; addr = 32'h0000_0102;
        #1;
        checkOutput("strict_idle_stall", stall_b, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("strict_err", err_b, 1'b1);
        checkOutput("strict_mreq", m_req_b, 1'b0);
        checkOutput("strict_stall", stall_b, 1'b0);
        req_valid2 = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("strict_err_clear", err_b, 1'b0);

        $display("[TB] withheld grant then reset mid-access");
        @(negedge clk);
        req_valid = 1'b1; wr_en = 1'b0; rd_en = 1'b1; mem_size = 2'b10; sz_ex = 1'b0;
        addr = 32'h0000_0300; m_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput("hold_mreq", m_req, 1'b1);
            checkOutput("hold_maddr", m_addr, 32'h0000_0300);
            checkOutput("hold_mbe", m_be, 4'hF);
        end
        m_gnt = 1'b1;
        @(negedge clk);
        #1;
        m_gnt = 1'b0;
        checkOutput("wait_stall", stall, 1'b1);
        checkOutput("wait_mreq", m_req, 1'b0);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("abort_stall", stall, 1'b0);
        checkOutput("abort_mreq", m_req, 1'b0);
        checkOutput("abort_mwe", m_we, 1'b0);
        checkOutput("abort_maddr", m_addr, 32'h0);
        checkOutput("abort_mbe", m_be, 4'h0);
        checkOutput("abort_mwdata", m_wdata, 32'h0);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_rdata", rdata, 32'h0);
        rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h5555_AAAA;
        @(negedge clk);
        #1;
        m_rvalid = 1'b0;
        checkOutput("stray_rvalid_done", done, 1'b0);
        checkOutput("stray_rvalid_stall", stall, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("stray_rvalid_done2", done, 1'b0);

        $display("[TB] random accesses");
        for (int t = 0; t < 60; t++) begin
            ra = ($urandom_range(0, 1) == 0) ? 32'h0000_0100 : 32'hFFFF_FFF8;
            ra = ra + $urandom_range(0, 15);
            rs = 2'($urandom_range(0, 3));
            if (rs == 2'b11 && $urandom_range(0, 3) != 0) rs = 2'b10;
            if (rs == 2'b11) begin
                applyError(ra);
            end else begin
                applyStimulus(1'($urandom), rs, 1'($urandom), ra, $urandom,
                              $urandom_range(0, 3), $urandom_range(0, 2));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences memory-stage load/store requests from the MEM pipeline register onto a word-wide data memory port with a req/gnt/rvalid handshake. Generates byte enables, and splits misaligned halfword/word accesses into two word beats. Merges and sign/zero-extends load data, and stalls the pipeline until the access retires. Sits between the MEM-stage control register outputs (wr_en, mem_size, sz_ex) and the data memory.

Parameters:
ADDR_W, 32, byte address width; word address wraps modulo 2^ADDR_W.
ALLOW_MISALIGN, 1, 1 = split misaligned accesses into two beats; 0 = flag misaligned accesses as err with no memory access.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  MEM stage holds a valid instruction; inputs stay stable while stall=1
wr_en  in  1  store
rd_en  in  1  load; ignored when wr_en=1
mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal
sz_ex  in  1  1 = sign-extend load, 0 = zero-extend
addr  in  ADDR_W  byte address
wdata  in  32  store data, LSB-aligned
stall  out  1  freeze pipeline
done  out  1  one-cycle pulse: access retired
rdata  out  32  extended load data, valid when done=1
err  out  1  one-cycle pulse: illegal size or disallowed misalign
m_req  out  1  memory request
m_we  out  1  memory write
m_addr  out  ADDR_W  word-aligned address (bits[1:0]=0)
m_be  out  4  byte lane enables
m_wdata  out  32  lane-positioned write data
m_gnt  in  1  request accepted this cycle
m_rvalid  in  1  read data valid (reads only, at least 1 cycle after gnt)
m_rdata  in  32  read data word

Behaviour:
- Reset: state IDLE; stall, done, err, m_req, m_we = 0; m_be = 0; m_addr, m_wdata, rdata = 0. Reset mid-access aborts immediately and drops m_req. A stray m_rvalid after reset is ignored.
- Access size and offset: n = 1/2/4 bytes; off = addr[1:0]. Split when off+n > 4.
- Beat0:
  - m_addr = addr & ~3.
  - m_be = lanes off..min(off+n-1,3).
  - m_wdata = wdata << 8*off.
- Beat1:
  - m_addr = (addr & ~3) + 4, with wrap.
  - m_be = lanes 0..off+n-5.
  - m_wdata = wdata >> 8*(4-off).
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, ERR.
- IDLE:
  - req_valid with wr_en|rd_en, legal size and allowed alignment → REQ0.
  - Illegal size, or misaligned with ALLOW_MISALIGN=0 → ERR.
  - Otherwise stay in IDLE with stall=0.
- REQ0: m_req=1 with beat0 fields held stable until m_gnt.
  - On gnt, a store goes to REQ1 if split, else DONE.
  - On gnt, a load goes to WAIT0.
- WAIT0: on m_rvalid, capture beat0 data; go to REQ1 if split, else DONE.
- REQ1/WAIT1: same as REQ0/WAIT0 using beat1 fields, ending in DONE.
- DONE: done=1, stall=0, rdata valid; next state IDLE. req_valid is ignored in DONE because the same instruction is still presented while the pipeline advances.
- ERR: err=1, stall=0, no m_req; next state IDLE.
- stall is combinational and is 1 in each of these cases:
  - IDLE when the request will start an access.
  - REQ0, WAIT0, REQ1, WAIT1.
- Store minimum latency: 1 cycle in REQ0, then done on the next cycle.
- Load minimum latency: gnt, rvalid next cycle, done the following cycle.
- Load merge: {beat1,beat0} >> 8*off, truncated to n bytes. Extension uses sz_ex on bit 8n-1. Words are never extended.
- m_gnt and m_rvalid in the same cycle never apply to the same beat; m_rvalid outside WAIT0/WAIT1 is ignored.
- m_req is never asserted in IDLE, DONE or ERR.

Test Plan:
- Aligned word store, addr=0x100, wdata=0xDEADBEEF, gnt on first REQ cycle → single beat: m_addr=0x100, m_be=1111, m_wdata=0xDEADBEEF. done one cycle later; stall high exactly 1 cycle.
- Byte load, sz_ex=1, addr=0x203, m_rdata=0x80112233 → m_be=1000, rdata=0xFFFFFF80. Same with sz_ex=0 → rdata=0x00000080.
- Misaligned word load, addr=0x106, beat0 rdata=0xAABBCCDD, beat1 rdata=0x11223344:
  - beat0 m_addr=0x104, be=1100; beat1 m_addr=0x108, be=0011.
  - rdata=0x3344AABB.
- Misaligned half store, addr=0xFFFFFFFF, wdata=0x1234:
  - beat0 m_addr=0xFFFFFFFC, be=1000, m_wdata=0x34000000.
  - beat1 m_addr=0x00000000, be=0001, m_wdata[7:0]=0x12.
- mem_size=11, or misaligned with ALLOW_MISALIGN=0 → err pulse, no m_req, stall 0.
- gnt withheld 5 cycles, then rst asserted in WAIT0 → m_req stable for the 5 cycles. After rst, all outputs are 0 and a late m_rvalid produces no done.
